rnn_layer_sequencer: RTL and testbench
======================================

# rnn_layer_sequencer

Frame-level controller for the denoising RNN datapath. It runs one inference per `frame_start` by firing the six layer engines in dependency order: dense1, gru1, dense2, gru2, gru3, dense3. It uses their start/valid handshakes, strobes the GRU state-register latches between layers, and optionally zeroes recurrent state at stream start. It sits above the layer engines and replaces ad-hoc valid-to-start chaining with a single FSM that adds a per-layer watchdog.

## Interface
Parameters:
- `NUM_LAYERS`, 6, number of layer engines (fixed order, index 0..5)
- `TIMEOUT_CYCLES`, 65535, maximum cycles a layer may hold start without valid
- `CNT_W`, 16, width of `frame_count` and the watchdog counter

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `frame_start`  in  1  pulse; request one inference (accepted in IDLE only)
- `state_clear`  in  1  sampled with `frame_start`; zero all GRU states before this frame
- `layer_valid`  in  6  per-engine completion pulse; bit k from engine k
- `layer_start`  out  6  one-hot level; bit k held high while engine k runs
- `state_load`  out  3  one-cycle pulse; [0] vad, [1] noise, [2] denoise state register latch
- `state_zero`  out  1  one-cycle pulse; clear all three GRU state registers
- `frame_busy`  out  1  high in every non-IDLE state
- `frame_done`  out  1  one-cycle pulse at end of frame
- `frame_err`  out  1  one-cycle pulse coincident with `frame_done` when a layer timed out
- `cur_layer`  out  3  index of active layer; 7 when no layer is active
- `frame_count`  out  CNT_W  frames completed without error; wraps modulo 2^CNT_W

## Operation
- FSM states:
  - IDLE, CLEAR, RUN(k), LOAD(g), DONE.
  - All outputs are decoded from registered state and counters; there are no combinational input-to-output paths.
- IDLE:
  - `frame_start`=1 goes to CLEAR if `state_clear`=1, else to RUN(0).
  - `frame_start` is ignored in all other states; it is neither queued nor latched.
- CLEAR:
  - Lasts one cycle with `state_zero`=1, then goes to RUN(0).
- RUN(k):
  - `layer_start[k]`=1 and `cur_layer`=k.
  - The watchdog is cleared on entry and increments each cycle.
  - On `layer_valid[k]`: if k is a GRU layer (1, 3, 4), go to LOAD(g) with g = 0, 1, 2 respectively. Otherwise go to RUN(k+1), or to DONE when k=5.
  - `layer_valid` bits other than k are ignored.
- LOAD(g):
  - Lasts one cycle with `state_load[g]`=1 and `layer_start`=0, then goes to RUN(k+1).
- Timeout:
  - The watchdog reaching TIMEOUT_CYCLES−1 in RUN(k) without `layer_valid[k]` drops start and goes to DONE with the error flag set.
  - If `layer_valid[k]` and the timeout occur in the same cycle, valid wins.
- DONE:
  - Lasts one cycle with `frame_done`=1 and `frame_err`=error flag.
  - `frame_count` increments only if the error flag is clear.
  - The error flag then clears and the FSM returns to IDLE.

## Timing
- Reset values:
  - All outputs are 0 except `cur_layer`=7.
  - FSM is in IDLE, watchdog=0, error flag=0.
  - Reset asserted mid-frame aborts immediately with no `frame_done`. Engines must tolerate `layer_start` dropping.
- `frame_start` sampled at edge t:
  - `layer_start[0]` is high from cycle t+1, or from t+2 when `state_clear`=1 (`state_zero` high in t+1).
  - `frame_busy` rises in the same cycle the FSM leaves IDLE.
- `layer_valid[k]` sampled at edge e:
  - `layer_start[k]` is low from e+1.
  - Non-GRU k: `layer_start[k+1]` is high in e+1.
  - GRU k: `state_load` pulses in e+1 and `layer_start[k+1]` is high in e+2.
  - k=5: `frame_done` pulses in e+1, `frame_busy` falls in e+2, and a new `frame_start` can be accepted at edge e+2.
- Sequencing overhead per frame is 1 + 3 LOAD + 1 DONE = 5 cycles, plus 1 when clearing.
- Watchdog compare is `==` TIMEOUT_CYCLES−1 on a CNT_W-bit counter. TIMEOUT_CYCLES ≤ 2^CNT_W.

## Structure
- Shared package `rnn_seq_pkg` holds:
  - layer index constants (L_DENSE1=0 … L_DENSE3=5)
  - FSM state enum
  - `GRU_LAYER_MASK` = 6'b011010
  - the layer-to-`state_load` bit mapping
  - `CUR_LAYER_NONE`=3'd7
- Sub-module `layer_watchdog` is a loadable CNT_W counter with clear and expire outputs.

## Test plan
- Reset, then `frame_start` with `state_clear`=0, each engine returning valid 3 cycles after start → `layer_start` walks bits 0..5. Pulses on `state_load` are 1, 2, 4 after layers 1, 3, 4. `frame_done` occurs with `frame_err`=0 and `frame_count`=1.
- `frame_start` with `state_clear`=1 → `state_zero` high for exactly one cycle, then `layer_start`=6'b000001 the next cycle.
- Engine 3 never responds, TIMEOUT_CYCLES=16 → `layer_start[3]` is high for 16 cycles, then drops. `frame_done` and `frame_err` pulse together and `frame_count` is unchanged.
- Valid on layer 2 in the same cycle as the watchdog expiry → the frame continues with no error.
- `frame_start` pulsed while busy and stray `layer_valid[5]` during RUN(1) → both are ignored and the sequence is unaffected.
- `rst` asserted during LOAD(1) → next cycle all outputs are 0 and `cur_layer`=7. A following `frame_start` runs a full clean frame.

Source files
------------

// File: rtl/rnn_seq_pkg.sv
// Shared constants, state encoding and layer-to-latch mapping for the RNN
// frame sequencer.
package rnn_seq_pkg;

    localparam logic [2:0] L_DENSE1 = 3'd0;
    localparam logic [2:0] L_GRU1   = 3'd1;
    localparam logic [2:0] L_DENSE2 = 3'd2;
    localparam logic [2:0] L_GRU2   = 3'd3;
    localparam logic [2:0] L_GRU3   = 3'd4;
    localparam logic [2:0] L_DENSE3 = 3'd5;

    localparam logic [5:0] GRU_LAYER_MASK = 6'b011010;
    localparam logic [2:0] CUR_LAYER_NONE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // GRU layer index -> one-hot state_load bit (vad, noise, denoise).
    function automatic logic [2:0] load_bit(input logic [2:0] layer);
        logic [2:0] bit_v;
        case (layer)
            L_GRU1:  bit_v = 3'b001;
            L_GRU2:  bit_v = 3'b010;
            L_GRU3:  bit_v = 3'b100;
            default: bit_v = 3'b000;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/rnn_layer_sequencer_watchdog.sv
// Per-layer watchdog: loadable up-counter that flags expiry when it reaches
// TIMEOUT_CYCLES-1.
module layer_watchdog #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == LIMIT);

endmodule

// File: rtl/rnn_layer_sequencer.sv
// Frame-level sequencer firing the six RNN layer engines in order, strobing
// GRU state latches between layers, with a per-layer watchdog.
module rnn_layer_sequencer
    import rnn_seq_pkg::*;
#(
    parameter int NUM_LAYERS     = 6,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  state_clear,
    input  logic [NUM_LAYERS-1:0] layer_valid,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [2:0]            state_load,
    output logic                  state_zero,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [2:0]            cur_layer,
    output logic [CNT_W-1:0]      frame_count
);

    function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [2:0] idx);
        logic [NUM_LAYERS-1:0] one_v;
        one_v = {{(NUM_LAYERS-1){1'b0}}, 1'b1};
        return one_v << idx;
    endfunction

    seq_state_e state_r, state_next_s;
    logic [2:0] layer_r, layer_next_s;
    logic       err_r, err_next_s;
    logic       valid_hit_s, is_gru_s;
    logic       wd_clear_s, wd_enable_s, wd_expire_s;

    logic [NUM_LAYERS-1:0] start_next_s, layer_start_r;
    logic [2:0]            load_next_s, state_load_r;
    logic [2:0]            cur_next_s, cur_layer_r;
    logic [CNT_W-1:0]      count_next_s, frame_count_r;
    logic                  zero_next_s, busy_next_s, done_next_s, ferr_next_s;
    logic                  state_zero_r, frame_busy_r, frame_done_r, frame_err_r;

    assign valid_hit_s = |(layer_valid & layer_onehot(layer_r));
    assign is_gru_s    = |(GRU_LAYER_MASK & layer_onehot(layer_r));

    layer_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clear      (wd_clear_s),
        .load       (1'b0),
        .load_value ({CNT_W{1'b0}}),
        .enable     (wd_enable_s),
        .expire     (wd_expire_s)
    );

    // Next-state logic; a valid in the expiry cycle takes priority over timeout.
    always_comb begin
        state_next_s = state_r;
        layer_next_s = layer_r;
        err_next_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    layer_next_s = L_DENSE1;
                    state_next_s = state_clear ? ST_CLEAR : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_next_s = ST_RUN;
                layer_next_s = L_DENSE1;
            end
            ST_RUN: begin
                if (valid_hit_s) begin
                    if (is_gru_s) begin
                        state_next_s = ST_LOAD;
                    end else if (layer_r == L_DENSE3) begin
                        state_next_s = ST_DONE;
                    end else begin
                        layer_next_s = layer_r + 3'd1;
                    end
                end else if (wd_expire_s) begin
                    state_next_s = ST_DONE;
                    err_next_s   = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_RUN;
                layer_next_s = layer_r + 3'd1;
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                err_next_s   = 1'b0;
                layer_next_s = L_DENSE1;
            end
            default: begin
                state_next_s = ST_IDLE;
                err_next_s   = 1'b0;
                layer_next_s = L_DENSE1;
            end
        endcase
    end

    // Watchdog restarts on every entry into a RUN state and counts while staying.
    always_comb begin
        if ((state_r == ST_RUN) && (state_next_s == ST_RUN) && (layer_next_s == layer_r)) begin
            wd_clear_s  = 1'b0;
            wd_enable_s = 1'b1;
        end else begin
            wd_clear_s  = 1'b1;
            wd_enable_s = 1'b0;
        end
    end

    // Output decode from the next state so registered outputs align with the state.
    always_comb begin
        start_next_s = {NUM_LAYERS{1'b0}};
        load_next_s  = 3'b000;
        cur_next_s   = CUR_LAYER_NONE;
        zero_next_s  = 1'b0;
        done_next_s  = 1'b0;
        ferr_next_s  = 1'b0;
        busy_next_s  = (state_next_s != ST_IDLE);
        count_next_s = frame_count_r;
        case (state_next_s)
            ST_RUN: begin
                start_next_s = layer_onehot(layer_next_s);
                cur_next_s   = layer_next_s;
            end
            ST_LOAD: begin
                load_next_s = load_bit(layer_next_s);
            end
            ST_CLEAR: begin
                zero_next_s = 1'b1;
            end
            ST_DONE: begin
                done_next_s = 1'b1;
                ferr_next_s = err_next_s;
                if (!err_next_s) begin
                    count_next_s = frame_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    count_next_s = frame_count_r;
                end
            end
            default: begin
                start_next_s = {NUM_LAYERS{1'b0}};
            end
        endcase
    end

    // State, error flag and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            layer_r       <= L_DENSE1;
            err_r         <= 1'b0;
            layer_start_r <= {NUM_LAYERS{1'b0}};
            state_load_r  <= 3'b000;
            state_zero_r  <= 1'b0;
            frame_busy_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            cur_layer_r   <= CUR_LAYER_NONE;
            frame_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            layer_r       <= layer_next_s;
            err_r         <= err_next_s;
            layer_start_r <= start_next_s;
            state_load_r  <= load_next_s;
            state_zero_r  <= zero_next_s;
            frame_busy_r  <= busy_next_s;
            frame_done_r  <= done_next_s;
            frame_err_r   <= ferr_next_s;
            cur_layer_r   <= cur_next_s;
            frame_count_r <= count_next_s;
        end
    end

    assign layer_start = layer_start_r;
    assign state_load  = state_load_r;
    assign state_zero  = state_zero_r;
    assign frame_busy  = frame_busy_r;
    assign frame_done  = frame_done_r;
    assign frame_err   = frame_err_r;
    assign cur_layer   = cur_layer_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_rnn_layer_sequencer.sv
// Scoreboard bench: frames are planned from the timing rules into an input
// schedule plus expected output snapshots; a monitor compares them on the fly.
module tb_rnn_layer_sequencer;

    localparam int TO   = 16;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst, frame_start, state_clear;
    logic [5:0] layer_valid;
    logic [5:0] layer_start;
    logic [2:0] state_load, cur_layer;
    logic       state_zero, frame_busy, frame_done, frame_err;
    logic [15:0] frame_count;

    rnn_layer_sequencer #(.NUM_LAYERS(6), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .state_clear(state_clear),
        .layer_valid(layer_valid), .layer_start(layer_start), .state_load(state_load),
        .state_zero(state_zero), .frame_busy(frame_busy), .frame_done(frame_done),
        .frame_err(frame_err), .cur_layer(cur_layer), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] snap;
        string       what;
    } ev_t;

    ev_t      sb[$];
    bit       rst_q [MAXC];
    bit       fs_q  [MAXC];
    bit       clr_q [MAXC];
    bit       probe_q [MAXC];
    bit [5:0] vld_q [MAXC];
    bit [5:0] runm  [MAXC];
    int       gslot [6] = '{-1, 0, -1, 1, 2, -1};

    int cyc_n = 0;
    int model_cnt = 0;
    int t_next;
    int last_cyc;
    int vectors = 0;
    int miscompares = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] mk_snap(input logic [5:0] st, input logic [2:0] ld,
                                            input logic z, input logic busy, input logic dn,
                                            input logic er, input logic [2:0] cur, input int cnt);
        logic [15:0] c16;
        c16 = cnt[15:0];
        return {st, ld, z, busy, dn, er, cur, c16};
    endfunction

    task automatic push(input int c, input logic [31:0] s, input string w);
        ev_t e;
        e.cyc = c; e.snap = s; e.what = w;
        sb.push_back(e);
        probe_q[c] = 1'b1;
    endtask

    // Cycle n = interval after clock edge n; inputs in slot n are sampled at edge n.
    task automatic plan_frame(input bit clr, input int d [6], input bit rst_l1, input bit noisy);
        int t, c, e, fe, s1, lim;
        bit err, aborted, saw1;
        t = t_next; c = t; fe = t; s1 = t; err = 1'b0; aborted = 1'b0; saw1 = 1'b0;
        fs_q[t] = 1'b1; clr_q[t] = clr;
        if (clr) begin
            push(c, mk_snap(6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, model_cnt), "state_zero");
            c++;
        end
        for (int k = 0; k < 6; k++) begin
            push(c, mk_snap(6'(1 << k), 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(k), model_cnt), "layer_start");
            if (k == 1) begin s1 = c; saw1 = 1'b1; end
            if (d[k] < 1 || d[k] > TO) begin
                for (int n = c + 1; n <= c + TO; n++) runm[n][k] = 1'b1;
                fe = c + TO; err = 1'b1;
                break;
            end
            e = c + d[k];
            for (int n = c + 1; n <= e; n++) runm[n][k] = 1'b1;
            vld_q[e][k] = 1'b1;
            if (gslot[k] >= 0) begin
                push(e, mk_snap(6'd0, 3'(1 << gslot[k]), 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, model_cnt), "state_load");
                if (rst_l1 && k == 3) begin
                    fe = e + 1; rst_q[fe] = 1'b1; aborted = 1'b1;
                    break;
                end
                c = e + 1;
            end else if (k == 5) begin
                fe = e;
            end else begin
                c = e;
            end
        end
        if (aborted) begin
            model_cnt = 0;
            push(fe, mk_snap(6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 0), "reset_abort");
            lim = fe - 1;
            t_next = fe + 1 + $urandom_range(1, 3);
        end else begin
            if (!err) model_cnt = (model_cnt + 1) % 65536;
            push(fe, mk_snap(6'd0, 3'd0, 1'b0, 1'b1, 1'b1, err, 3'd7, model_cnt), "frame_done");
            push(fe + 1, mk_snap(6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, model_cnt), "idle");
            lim = fe + 1;
            t_next = fe + 2 + $urandom_range(0, 3);
        end
        if (noisy) begin
            if (saw1) vld_q[s1 + 1][5] = 1'b1;
            for (int n = t + 1; n <= lim; n++) begin
                if ($urandom_range(0, 4) == 0) begin
                    fs_q[n] = 1'b1; clr_q[n] = 1'($urandom_range(0, 1));
                end
                if (n <= fe && $urandom_range(0, 3) == 0)
                    vld_q[n] = vld_q[n] | (6'($urandom) & ~runm[n]);
            end
        end
    endtask

    task automatic apply(input int n);
        if (n < MAXC) begin
            rst = rst_q[n]; frame_start = fs_q[n]; state_clear = clr_q[n]; layer_valid = vld_q[n];
        end else begin
            rst = 1'b0; frame_start = 1'b0; state_clear = 1'b0; layer_valid = 6'd0;
        end
    endtask

    // Monitor: compare whenever the DUT shows an event or a planned check is due.
    logic [5:0]  prev_start = 6'd0;
    logic [31:0] got;
    bit          dut_ev;
    ev_t         exp_e;
    always @(negedge clk) begin
        if (cyc_n >= 1 && cyc_n < MAXC) begin
            dut_ev = (frame_done === 1'b1) || (state_zero === 1'b1) || (state_load !== 3'd0) ||
                     ((layer_start !== prev_start) && (layer_start !== 6'd0));
            if (dut_ev || probe_q[cyc_n]) begin
                got = {layer_start, state_load, state_zero, frame_busy, frame_done, frame_err,
                       cur_layer, frame_count};
                vectors++;
                if (sb.size() == 0 || sb[0].cyc != cyc_n) begin
                    miscompares++;
                    $display("FAIL unexpected_event: cycle %0d got snapshot %h, none expected here", cyc_n, got);
                end else begin
                    exp_e = sb.pop_front();
                    if (got !== exp_e.snap) begin
                        miscompares++;
                        $display("FAIL %s: cycle %0d got %h expected %h", exp_e.what, cyc_n, got, exp_e.snap);
                    end
                end
            end
            prev_start = layer_start;
        end
    end

    initial begin
        int d [6];
        for (int i = 1; i <= 3; i++) begin
            rst_q[i] = 1'b1;
            push(i, mk_snap(6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 0), "reset_state");
        end
        push(4, mk_snap(6'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 0), "idle_after_reset");
        t_next = 6;

        d = '{3, 3, 3, 3, 3, 3};   plan_frame(1'b0, d, 1'b0, 1'b0);
        d = '{2, 5, 1, 4, 2, 3};   plan_frame(1'b1, d, 1'b0, 1'b0);
        d = '{2, 2, 2, 0, 2, 2};   plan_frame(1'b0, d, 1'b0, 1'b0);
        d = '{1, 3, 16, 2, 16, 1}; plan_frame(1'b0, d, 1'b0, 1'b0);
        d = '{3, 6, 2, 2, 2, 2};   plan_frame(1'b0, d, 1'b0, 1'b1);
        d = '{2, 2, 2, 3, 2, 2};   plan_frame(1'b1, d, 1'b1, 1'b0);
        d = '{2, 2, 2, 2, 2, 2};   plan_frame(1'b0, d, 1'b0, 1'b0);
        for (int f = 0; f < 20 && t_next < MAXC - 300; f++) begin
            for (int k = 0; k < 6; k++)
                d[k] = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, TO);
            plan_frame(1'($urandom_range(0, 1)), d, 1'b0, 1'b1);
        end
        last_cyc = t_next + 4;

        apply(1);
        repeat (last_cyc) begin
            @(negedge clk);
            apply(cyc_n + 1);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_events: %0d expected events never seen, first due at cycle %0d (%s)",
                     sb.size(), sb[0].cyc, sb[0].what);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
